// File: rtl/instr_mem_loadable_if.sv
// instr_mem_loadable_if: fetch port and byte-stream loader bus of the instruction memory.
// IMEM_PARITY_EN adds the parity_err / inj_parity signals.
interface instr_mem_loadable_if #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 64
);
  localparam int WW = $clog2(DEPTH_WORDS) + 1;
  logic              freeze;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              misaligned;
  logic              out_of_range;
  logic              ld_start;
  logic              ld_byte_valid;
  logic [7:0]        ld_byte;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic [WW-1:0]     ld_words;
`ifdef IMEM_PARITY_EN
  logic              parity_err;
  logic              inj_parity;
`endif
  modport master (
`ifdef IMEM_PARITY_EN
    input  parity_err,
    output inj_parity,
`endif
    output freeze, pc, ld_start, ld_byte_valid, ld_byte, ld_last,
    input  instruction, instr_valid, misaligned, out_of_range, ld_ready, ld_done, ld_words
  );
  modport slave (
`ifdef IMEM_PARITY_EN
    output parity_err,
    input  inj_parity,
`endif
    input  freeze, pc, ld_start, ld_byte_valid, ld_byte, ld_last,
    output instruction, instr_valid, misaligned, out_of_range, ld_ready, ld_done, ld_words
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: loadable word memory with registered, freezable, range-checked fetch port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag mismatches on fetch.
module instr_mem_loadable #(
  parameter int ADDR_W                    = 32,
  parameter int DEPTH_WORDS               = 64,
  parameter int DATA_W                    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD   = 32'hE1A00000
) (
  input logic clk,
  input logic rst,
  instr_mem_loadable_if.slave bus
);
  localparam int BPW = DATA_W / 8;
  localparam int BW  = $clog2(BPW);
  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam logic [BW-1:0] LAST_LANE = BW'(BPW - 1);
  localparam logic [AW:0]   LAST_WORD = (AW + 1)'(DEPTH_WORDS - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t            state_q;
  logic [BW-1:0]     lane_q;
  logic [AW:0]       wptr_q, words_q;
  logic [DATA_W-1:0] asm_q, word_d, instr_q;
  logic              valid_q, mis_q, oor_q, ready_q, done_q;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic              take, wr_en, last_d, mis_d, oor_d, perr, ok;
  logic [AW-1:0]     ridx;
  assign take   = state_q == LOAD && ready_q && bus.ld_byte_valid;
  assign wr_en  = take && (bus.ld_last || lane_q == LAST_LANE);
  assign last_d = bus.ld_last || wptr_q == LAST_WORD;
  assign mis_d  = |bus.pc[BW-1:0];
  assign oor_d  = |bus.pc[ADDR_W-1:BW+AW];
  assign ridx   = bus.pc[BW+AW-1:BW];
  assign ok     = !mis_d && !oor_d && !perr;
  // Lanes below the current one are already assembled; lanes above pad with NOP bytes.
  always_comb begin
    word_d = asm_q;
    for (int i = 0; i < BPW; i++)
      word_d[8*i +: 8] = BW'(i) < lane_q ? asm_q[8*i +: 8] :
                         BW'(i) == lane_q ? bus.ld_byte : NOP_WORD[8*i +: 8];
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wptr_q[AW-1:0]] <= word_d;
`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH_WORDS];
  logic perr_q;
  assign perr = par_mem[ridx] ^ (^mem[ridx]);
  assign bus.parity_err = perr_q;
  always_ff @(posedge clk)
    if (wr_en) par_mem[wptr_q[AW-1:0]] <= (^word_d) ^ bus.inj_parity;
  always_ff @(posedge clk or negedge rst)
    if (!rst) perr_q <= 1'b0;
    else if (state_q != IDLE) perr_q <= 1'b0;
    else if (!bus.freeze) perr_q <= !mis_d && !oor_d && perr;
`else
  assign perr = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      wptr_q  <= '0;
      asm_q   <= '0;
      words_q <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      oor_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (state_q != IDLE) begin
        instr_q <= NOP_WORD;
        valid_q <= 1'b0;
        mis_q   <= 1'b0;
        oor_q   <= 1'b0;
      end else if (!bus.freeze) begin
        instr_q <= ok ? mem[ridx] : NOP_WORD;
        valid_q <= ok;
        mis_q   <= mis_d;
        oor_q   <= oor_d;
      end
      case (state_q)
        IDLE: if (bus.ld_start) begin
          state_q <= LOAD;
          lane_q  <= '0;
          wptr_q  <= '0;
          asm_q   <= '0;
          ready_q <= 1'b1;
        end
        LOAD: if (take) begin
          asm_q  <= word_d;
          lane_q <= wr_en ? '0 : lane_q + 1'b1;
          if (wr_en) wptr_q <= wptr_q + 1'b1;
          if (wr_en && last_d) begin
            state_q <= DONE;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
            words_q <= wptr_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.instruction  = instr_q;
  assign bus.instr_valid  = valid_q;
  assign bus.misaligned   = mis_q;
  assign bus.out_of_range = oor_q;
  assign bus.ld_ready     = ready_q;
  assign bus.ld_done      = done_q;
  assign bus.ld_words     = words_q;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: directed load/fetch vectors with hand-computed expectations.
module tb_instr_mem_loadable;
  localparam logic [31:0] NOP = 32'hE1A00000;
  logic clk, rst;
  int   n_checks = 0, n_err = 0;
  instr_mem_loadable_if bus ();
  instr_mem_loadable dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic last);
    bus.ld_byte_valid = 1'b1;
    bus.ld_byte       = b;
    bus.ld_last       = last;
    tick();
    bus.ld_byte_valid = 1'b0;
    bus.ld_last       = 1'b0;
  endtask
  task automatic fetch(input logic [31:0] p);
    bus.pc     = p;
    bus.freeze = 1'b0;
    tick();
  endtask
  function automatic logic [31:0] fw(input int w);
    return {8'h3C, 8'hA5, 8'(w) ^ 8'h55, 8'(w)};
  endfunction
  initial begin
    rst = 1'b0;
    bus.freeze = 1'b0;
    bus.pc = '0;
    bus.ld_start = 1'b0;
    bus.ld_byte_valid = 1'b0;
    bus.ld_byte = '0;
    bus.ld_last = 1'b0;
`ifdef IMEM_PARITY_EN
    bus.inj_parity = 1'b0;
`endif
    repeat (3) tick();
    check("rst_instr", bus.instruction, NOP);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_mis", bus.misaligned, 0);
    check("rst_oor", bus.out_of_range, 0);
    check("rst_ready", bus.ld_ready, 0);
    check("rst_done", bus.ld_done, 0);
    check("rst_words", bus.ld_words, 0);
    rst = 1'b1;
    #1;
    check("rel_instr", bus.instruction, NOP);
    check("rel_valid", bus.instr_valid, 0);
    // Two full words
    start();
    check("ld_ready", bus.ld_ready, 1);
    send(8'h00, 0); send(8'h00, 0); send(8'hA0, 0); send(8'hE3, 0);
    check("load_fetch_nop", bus.instruction, NOP);
    check("load_fetch_valid", bus.instr_valid, 0);
    send(8'h14, 0); send(8'h00, 0); send(8'hA0, 0);
    check("done_early", bus.ld_done, 0);
    send(8'hE3, 1);
    check("done_pulse", bus.ld_done, 1);
    check("words2", bus.ld_words, 2);
    check("ready_off", bus.ld_ready, 0);
    tick();
    check("done_one_cycle", bus.ld_done, 0);
    fetch(0);
    check("w0_instr", bus.instruction, 32'hE3A00000);
    check("w0_valid", bus.instr_valid, 1);
    fetch(4);
    check("w1_instr", bus.instruction, 32'hE3A00014);
    check("w1_valid", bus.instr_valid, 1);
    // Partial word padded with NOP bytes
    start();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h11, 1);
    check("part_done", bus.ld_done, 1);
    check("part_words", bus.ld_words, 2);
    tick();
    fetch(4);
    check("pad_instr", bus.instruction, 32'hE1A00011);
    fetch(0);
    check("part_w0", bus.instruction, 32'h04030201);
    fetch(2);
    check("mis_flag", bus.misaligned, 1);
    check("mis_oor", bus.out_of_range, 0);
    check("mis_instr", bus.instruction, NOP);
    check("mis_valid", bus.instr_valid, 0);
    fetch(256);
    check("oor_flag", bus.out_of_range, 1);
    check("oor_mis", bus.misaligned, 0);
    check("oor_instr", bus.instruction, NOP);
    check("oor_valid", bus.instr_valid, 0);
    fetch(32'h8000_0000);
    check("oor_high", bus.out_of_range, 1);
    fetch(252);
    check("top_oor", bus.out_of_range, 0);
    check("top_mis", bus.misaligned, 0);
    // Freeze holds outputs
    fetch(4);
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pc = (i == 2) ? 32'd2 : 32'd0;
      tick();
      check("frz_instr", bus.instruction, 32'hE1A00011);
      check("frz_valid", bus.instr_valid, 1);
      check("frz_mis", bus.misaligned, 0);
    end
    fetch(0);
    check("unfrz_instr", bus.instruction, 32'h04030201);
    // Full 64-word load with an ignored mid-load ld_start
    start();
    for (int w = 0; w < 64; w++)
      for (int b = 0; b < 4; b++) begin
        if (w == 10 && b == 0) bus.ld_start = 1'b1;
        send(b == 0 ? 8'(w) : b == 1 ? 8'(w) ^ 8'h55 : b == 2 ? 8'hA5 : 8'h3C, 0);
        bus.ld_start = 1'b0;
      end
    check("full_ready", bus.ld_ready, 0);
    check("full_done", bus.ld_done, 1);
    check("full_words", bus.ld_words, 64);
    send(8'hFF, 0);
    check("extra_done", bus.ld_done, 0);
    check("extra_ready", bus.ld_ready, 0);
    fetch(0);
    check("full_w0", bus.instruction, fw(0));
    fetch(40);
    check("full_w10", bus.instruction, fw(10));
    fetch(252);
    check("full_w63", bus.instruction, fw(63));
    check("full_w63_valid", bus.instr_valid, 1);
    // Reset aborts a load
    start();
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    send(8'h11, 0); send(8'h22, 0);
    #2 rst = 1'b0;
    #1;
    check("abort_ready", bus.ld_ready, 0);
    check("abort_done", bus.ld_done, 0);
    tick();
    rst = 1'b1;
    tick();
    check("abort_no_done", bus.ld_done, 0);
    check("abort_words", bus.ld_words, 0);
    fetch(0);
    check("abort_w0", bus.instruction, 32'hDEADBEEF);
    check("abort_idle_valid", bus.instr_valid, 1);
    fetch(4);
    check("abort_w1", bus.instruction, fw(1));
    fetch(8);
    check("abort_w2", bus.instruction, fw(2));
`ifdef IMEM_PARITY_EN
    check("par_ok", bus.parity_err, 0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
